// File: rtl/psk_demod_pkg.sv
// Shared constants and types for the PSK demodulator slice.
package psk_demod_pkg;

   localparam int SAMPLES_PER_SYM = 16;
   localparam int PH_W            = 4;

   typedef logic [PH_W-1:0] ph_t;

   localparam ph_t PH_LAST = PH_W'(SAMPLES_PER_SYM - 1);

   typedef enum logic {
      MODE_QPSK = 1'b0,
      MODE_BPSK = 1'b1
   } mode_e;

   function automatic int acc_width(input int width);
      return 2 * width + 4;
   endfunction

   function automatic int tdata_width(input int bytes);
      return ((bytes < 1) ? 1 : bytes) * 8;
   endfunction

endpackage

// File: rtl/psk_integrate_dump.sv
// One branch of the demodulator: mix with carrier, integrate over a symbol, dump the sign.
module psk_integrate_dump
   import psk_demod_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic                    clk_16M384,
   input  logic                    rst_16M384,
   input  logic signed [WIDTH-1:0] in_smp,
   input  logic signed [WIDTH-1:0] carrier,
   input  logic                    s1_vld,
   input  ph_t                     ph,
   output logic                    dec_bit
);

   localparam int ACC_W = acc_width(WIDTH);
   localparam int PW    = 2 * WIDTH;

   logic signed [PW-1:0]    smp_x;
   logic signed [PW-1:0]    car_x;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] prod_x;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;

   always_comb begin
      smp_x  = {{WIDTH{in_smp[WIDTH-1]}}, in_smp};
      car_x  = {{WIDTH{carrier[WIDTH-1]}}, carrier};
      prod_x = {{(ACC_W-PW){prod[PW-1]}}, prod};
      sum    = acc + prod_x;
   end

   // prod is the stage-1 product; ph and s1_vld from the top describe that same sample
   always_ff @(posedge clk_16M384) begin
      if (rst_16M384) begin
         prod    <= '0;
         acc     <= '0;
         dec_bit <= 1'b0;
      end else begin
         prod <= smp_x * car_x;
         if (s1_vld)
            acc <= (ph == '0) ? prod_x : sum;
         if (s1_vld && ph == PH_LAST)
            dec_bit <= ~sum[ACC_W-1];
      end
   end

endmodule

// File: rtl/psk_demod.sv
// BPSK/QPSK integrate-and-dump demodulator, 16 samples per symbol, AXIS output.
module psk_demod
   import psk_demod_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int BYTES = 1
) (
   input  logic                           clk_16M384,
   input  logic                           rst_16M384,
   input  logic signed [WIDTH-1:0]        in_I,
   input  logic signed [WIDTH-1:0]        in_Q,
   input  logic                           in_vld,
   input  logic                           in_is_bpsk,
   input  logic                           in_last,
   input  logic signed [WIDTH-1:0]        carrier_I,
   input  logic signed [WIDTH-1:0]        carrier_Q,
   output logic [tdata_width(BYTES)-1:0]  m_tdata,
   output logic                           m_tvalid,
   input  logic                           m_tready,
   output logic                           m_tlast,
   output logic                           m_tuser,
   output logic                           overflow,
   output logic                           sym_clk_1M024
);

   localparam int DW = tdata_width(BYTES);

   logic  s1_vld, s1_last, s1_bpsk;
   ph_t   ph;
   mode_e mode_q, dec_mode;
   logic  last_q, dec_last, dec_vld;
   logic  dec_i, dec_q, q_bit;
   logic  sym_end;

   psk_integrate_dump #(.WIDTH(WIDTH)) u_int_i (
      .clk_16M384 (clk_16M384),
      .rst_16M384 (rst_16M384),
      .in_smp     (in_I),
      .carrier    (carrier_I),
      .s1_vld     (s1_vld),
      .ph         (ph),
      .dec_bit    (dec_i)
   );

   psk_integrate_dump #(.WIDTH(WIDTH)) u_int_q (
      .clk_16M384 (clk_16M384),
      .rst_16M384 (rst_16M384),
      .in_smp     (in_Q),
      .carrier    (carrier_Q),
      .s1_vld     (s1_vld),
      .ph         (ph),
      .dec_bit    (dec_q)
   );

   always_comb begin
      sym_end       = s1_vld && (ph == PH_LAST);
      q_bit         = (dec_mode == MODE_BPSK) ? 1'b0 : dec_q;
      sym_clk_1M024 = ~ph[PH_W-1];
   end

   always_ff @(posedge clk_16M384) begin
      if (rst_16M384) begin
         s1_vld   <= 1'b0;
         s1_last  <= 1'b0;
         s1_bpsk  <= 1'b0;
         ph       <= '0;
         mode_q   <= MODE_QPSK;
         last_q   <= 1'b0;
         dec_vld  <= 1'b0;
         dec_last <= 1'b0;
         dec_mode <= MODE_QPSK;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
         m_tuser  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         s1_vld  <= in_vld;
         s1_last <= in_last;
         s1_bpsk <= in_is_bpsk;

         // any invalid stage-1 slot abandons the symbol in progress
         ph <= s1_vld ? ph + 1'b1 : '0;

         if (s1_vld && ph == '0) begin
            mode_q <= mode_e'(s1_bpsk);
            last_q <= s1_last;
         end else if (s1_vld) begin
            last_q <= last_q | s1_last;
         end

         dec_vld <= sym_end;
         if (sym_end) begin
            dec_last <= last_q | s1_last;
            dec_mode <= mode_q;
         end

         if (dec_vld && (!m_tvalid || m_tready)) begin
            m_tvalid <= 1'b1;
            m_tdata  <= DW'({dec_i, q_bit});
            m_tlast  <= dec_last;
            m_tuser  <= (dec_mode == MODE_BPSK);
         end else if (dec_vld) begin
            overflow <= 1'b1;
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_psk_demod.sv
// Directed bench for psk_demod: latency, modes, gaps, backpressure, tlast and reset.
module tb_psk_demod;

   localparam int WIDTH = 12;
   localparam int BYTES = 1;

   logic                    clk_16M384 = 1'b0;
   logic                    rst_16M384 = 1'b1;
   logic signed [WIDTH-1:0] in_I = '0, in_Q = '0;
   logic                    in_vld = 1'b0, in_is_bpsk = 1'b0, in_last = 1'b0;
   logic signed [WIDTH-1:0] carrier_I = 12'sd1000, carrier_Q = 12'sd1000;
   logic [BYTES*8-1:0]      m_tdata;
   logic                    m_tvalid, m_tlast, m_tuser, overflow, sym_clk_1M024;
   logic                    m_tready = 1'b1;

   always #5 clk_16M384 = ~clk_16M384;

   psk_demod #(.WIDTH(WIDTH), .BYTES(BYTES)) dut (
      .clk_16M384    (clk_16M384),
      .rst_16M384    (rst_16M384),
      .in_I          (in_I),
      .in_Q          (in_Q),
      .in_vld        (in_vld),
      .in_is_bpsk    (in_is_bpsk),
      .in_last       (in_last),
      .carrier_I     (carrier_I),
      .carrier_Q     (carrier_Q),
      .m_tdata       (m_tdata),
      .m_tvalid      (m_tvalid),
      .m_tready      (m_tready),
      .m_tlast       (m_tlast),
      .m_tuser       (m_tuser),
      .overflow      (overflow),
      .sym_clk_1M024 (sym_clk_1M024)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       u;
   } beat_t;

   beat_t got_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   // handshake seen here completes on the following rising edge
   always @(negedge clk_16M384)
      if (!rst_16M384 && m_tvalid && m_tready)
         got_q.push_back({m_tdata, m_tlast, m_tuser});

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic beat_t peek(input int idx);
      beat_t b;
      b = 'x;
      if (idx < got_q.size())
         b = got_q[idx];
      return b;
   endfunction

   task automatic put(input int i, input int q, input bit v, input bit bpsk, input bit last);
      in_I       = WIDTH'(i);
      in_Q       = WIDTH'(q);
      in_vld     = v;
      in_is_bpsk = bpsk;
      in_last    = last;
      @(posedge clk_16M384);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) put(0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic sym(input int i, input int q, input bit b0, input bit brest, input int last_at);
      for (int s = 0; s < 16; s++)
         put(i, q, 1'b1, (s == 0) ? b0 : brest, s == last_at);
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk_16M384);
      #1;
      chk("rst_tvalid_rdy1", m_tvalid, 0);
      m_tready = 1'b0;
      @(posedge clk_16M384);
      #1;
      chk("rst_tvalid_rdy0", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_tuser", m_tuser, 0);
      chk("rst_symclk", sym_clk_1M024, 1);
      rst_16M384 = 1'b0;
      m_tready   = 1'b1;
      idle(2);

      // QPSK latency: 16th sample on edge k, valid after edge k+2 for one cycle
      got_q.delete();
      for (int s = 0; s < 16; s++) put(1000, -1000, 1'b1, 1'b0, 1'b0);
      chk("lat_k_tvalid", m_tvalid, 0);
      idle(1);
      chk("lat_k1_tvalid", m_tvalid, 0);
      idle(1);
      chk("lat_k2_tvalid", m_tvalid, 1);
      chk("lat_k2_tdata", m_tdata, 8'h02);
      chk("lat_k2_tuser", m_tuser, 0);
      chk("lat_k2_tlast", m_tlast, 0);
      idle(1);
      chk("lat_k3_tvalid", m_tvalid, 0);
      idle(2);

      // BPSK, plus mode changes mid-symbol that must be ignored
      got_q.delete();
      sym(-500, 700, 1'b1, 1'b1, -1);
      sym(-500, 700, 1'b1, 1'b0, -1);
      sym(-500, 700, 1'b0, 1'b1, -1);
      idle(4);
      chk("bpsk_count", got_q.size(), 3);
      chk("bpsk0_tdata", peek(0).d, 8'h00);
      chk("bpsk0_tuser", peek(0).u, 1);
      chk("bpsk1_tdata", peek(1).d, 8'h00);
      chk("bpsk1_tuser", peek(1).u, 1);
      chk("qpsk2_tdata", peek(2).d, 8'h01);
      chk("qpsk2_tuser", peek(2).u, 0);

      // valid gap at sample 9 discards the partial symbol
      got_q.delete();
      for (int s = 0; s < 9; s++) put(-2047, -2047, 1'b1, 1'b0, 1'b0);
      put(0, 0, 1'b0, 1'b0, 1'b0);
      sym(1000, 1000, 1'b0, 1'b0, -1);
      idle(4);
      chk("gap_count", got_q.size(), 1);
      chk("gap_tdata", peek(0).d, 8'h03);

      // backpressure: first symbol held, second dropped, overflow sticky
      got_q.delete();
      m_tready = 1'b0;
      for (int n = 0; n < 40; n++) begin
         put((n < 16) ? 1000 : -1000, (n < 16) ? 1000 : -1000, 1'b1, 1'b0, 1'b0);
         if (n == 24) begin
            chk("bp_mid_tvalid", m_tvalid, 1);
            chk("bp_mid_tdata", m_tdata, 8'h03);
            chk("bp_mid_overflow", overflow, 0);
         end
      end
      chk("bp_end_tvalid", m_tvalid, 1);
      chk("bp_end_tdata", m_tdata, 8'h03);
      chk("bp_end_overflow", overflow, 1);
      idle(3);
      chk("bp_hold_tdata", m_tdata, 8'h03);
      chk("bp_hold_count", got_q.size(), 0);
      m_tready = 1'b1;
      idle(3);
      chk("bp_rel_count", got_q.size(), 1);
      chk("bp_rel_tdata", peek(0).d, 8'h03);
      chk("bp_rel_tvalid", m_tvalid, 0);
      chk("bp_rel_overflow", overflow, 1);

      // tlast on sample 5 of symbol 3 only
      got_q.delete();
      for (int k = 0; k < 4; k++)
         sym((k % 2 == 1) ? -1000 : 1000, 1000, 1'b0, 1'b0, (k == 2) ? 5 : -1);
      idle(4);
      chk("last_count", got_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("last%0d_tlast", k), peek(k).l, (k == 2) ? 1 : 0);
         chk($sformatf("last%0d_tdata", k), peek(k).d, (k % 2 == 1) ? 8'h01 : 8'h03);
      end

      // reset mid-symbol
      got_q.delete();
      for (int s = 0; s < 9; s++) put(1000, 1000, 1'b1, 1'b0, 1'b0);
      chk("mid_symclk_ph8", sym_clk_1M024, 0);
      rst_16M384 = 1'b1;
      put(1000, 1000, 1'b1, 1'b0, 1'b0);
      chk("rst2_tvalid_a", m_tvalid, 0);
      m_tready = 1'b0;
      put(1000, 1000, 1'b1, 1'b0, 1'b0);
      chk("rst2_tvalid_b", m_tvalid, 0);
      put(1000, 1000, 1'b1, 1'b0, 1'b0);
      chk("rst2_tvalid_c", m_tvalid, 0);
      chk("rst2_overflow", overflow, 0);
      rst_16M384 = 1'b0;
      m_tready   = 1'b1;
      sym(-1000, -1000, 1'b0, 1'b0, -1);
      idle(4);
      chk("rst2_count", got_q.size(), 1);
      chk("rst2_tdata", peek(0).d, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
